multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control unit for the multicycle ARM-subset datapath: register file, ALU, single shared instruction/data memory, PC and instruction registers.
- Moore FSM sequences fetch, decode, execute and writeback over 3–5 cycles per instruction.
- Holds the NZCV flag register and evaluates the instruction condition field once per instruction, in DECODE.
- Waits on a memory-ready handshake for every memory access.

Parameters:
- STATE_W, 4, width of the state register.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  2  Instr[27:26]
- funct  in  6  Instr[25:20]: I, cmd[3:0], S/L
- rd  in  4  Instr[15:12]
- cond  in  4  Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- memReady  in  1  memory access completes this cycle
- PCWrite  out  1  PC load enable
- IRWrite  out  1  instruction register load enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  memory write strobe
- AdrSrc  out  1  0=PC, 1=ALU result register
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU direct
- ImmSrc  out  2  equals op
- RegSrc  out  2  [0]=(op==10), [1]=(op==01)
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr
- flags  out  4  current NZCV register

Behaviour:
- Reset low: state=FETCH, flags=0000. Write enables (PCWrite, IRWrite, RegWrite, MemWrite) forced to 0 while reset is low. Other outputs take their FETCH values.
- Reset mid-instruction aborts the instruction with no further writes; execution restarts in FETCH.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, HALT 10 (optional). Unlisted encodings go to FETCH.
- Unlisted outputs in each state are 0, ALUControl=add.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - IRWrite=PCWrite=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - condEx is evaluated on the registered flags: EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL, standard ARM semantics.
  - condEx=0 -> FETCH (instruction squashed, no writes).
  - Otherwise: op=01 -> MEMADR; op=00 with funct[5]=0 -> EXECR; op=00 with funct[5]=1 -> EXECI; op=10 -> BRANCH; op=11 -> FETCH (nop).
- MEMADR: ALUSrcA=0, ALUSrcB=01, add. funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD: AdrSrc=1. Holds until memReady, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, PCWrite=(rd==15). -> FETCH.
- MEMWR:
  - AdrSrc=1, MemWrite=1 held every cycle until memReady.
  - -> FETCH on the cycle memReady=1; MemWrite drops the next cycle.
- EXECR / EXECI:
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl from funct[4:1]: 0100 add, 0010 sub, 0000 and, 1100 orr, 1010 (CMP) sub. Other cmd values use add and suppress writeback.
  - Flag update at the clock edge leaving this state: if S=funct[0]=1, N,Z <= ALUFlags[3:2]. If the operation is also add/sub/CMP, C,V <= ALUFlags[1:0].
  - CMP always updates all four flags.
  - CMP or unsupported cmd -> FETCH; otherwise -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, PCWrite=(rd==15). -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, add, ResultSrc=10, PCWrite=1. -> FETCH.
- Latency:
  - Data processing: 4 cycles (3 for CMP).
  - Load: 5 cycles. Store: 4 cycles. Branch: 3 cycles.
  - Squashed instruction: 2 cycles.
  - Each memReady=0 cycle adds one cycle.
- Flags change only in EXECR/EXECI. A squashed instruction never alters flags.

Optional Feature:
- Macro: CTRL_HALT_EN.
- Defined: cond=1111 in DECODE -> HALT. HALT drives all write enables 0 and is left only by reset.
- Undefined: cond=1111 evaluates condEx=0 and the instruction is squashed (-> FETCH).

Test Plan:
- ADD R1,R2,#5 (op=00, funct=101000, cond=1110), memReady=1 -> states 0,1,7,8,0. RegWrite=1 only in ALUWB. Flags unchanged.
- SUBS R0,R0,R0 with ALUFlags=0110 in EXECR -> flags=0110 after EXECR. Next BEQ (cond=0000) visits BRANCH with PCWrite=1.
- LDR R15 (op=01, funct[0]=1, rd=1111), memReady low for 2 cycles in MEMRD -> MEMRD held 3 cycles. In MEMWB, RegWrite=PCWrite=1.
- STR with memReady=0 for 3 cycles -> MemWrite=1 for 4 consecutive cycles, then FETCH.
- BNE with flags Z=1 -> DECODE -> FETCH, no enable asserted. Reset pulse during MEMWR -> MemWrite=0 immediately, state=FETCH.
- cond=1111: with CTRL_HALT_EN, FSM stays in HALT for 20 cycles with all enables 0; without it, FSM returns to FETCH after DECODE.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control unit for the multicycle ARM-subset datapath: Moore FSM, NZCV flag register, condition check.
// Build option CTRL_HALT_EN: cond=1111 parks the FSM in HALT until reset.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rd,
  input  logic [3:0]  cond,
  input  logic [3:0]  ALUFlags,
  input  logic        memReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  flags
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXECR  = STATE_W'(6),
    EXECI  = STATE_W'(7),
    ALUWB  = STATE_W'(8),
    BRANCH = STATE_W'(9),
    HALT   = STATE_W'(10)
  } state_t;

  typedef struct packed {
    logic       pcw;
    logic       regw;
    logic       memw;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] aluc;
  } ctrl_t;

  state_t     state, state_n;
  ctrl_t      ctl;
  logic [1:0] aluc;
  logic       cmd_ok, arith, is_cmp;
  logic       fetch_go;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cy;
      4'b0011: r = !cy;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cy && !z;
      4'b1001: r = !cy || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State-only output decode; memReady-dependent FETCH enables are added outside the register.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [1:0] ac, input logic pc_dst);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH, DECODE: begin c.srca = 1'b1; c.srcb = 2'b10; c.res = 2'b10; end
      MEMADR: c.srcb = 2'b01;
      MEMRD:  c.adr = 1'b1;
      MEMWB:  begin c.res = 2'b01; c.regw = 1'b1; c.pcw = pc_dst; end
      MEMWR:  begin c.adr = 1'b1; c.memw = 1'b1; end
      EXECR:  c.aluc = ac;
      EXECI:  begin c.srcb = 2'b01; c.aluc = ac; end
      ALUWB:  begin c.regw = 1'b1; c.pcw = pc_dst; end
      BRANCH: begin c.srcb = 2'b01; c.res = 2'b10; c.pcw = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    aluc   = 2'b00;
    cmd_ok = 1'b1;
    arith  = 1'b0;
    is_cmp = 1'b0;
    case (funct[4:1])
      4'b0100: arith = 1'b1;
      4'b0010: begin aluc = 2'b01; arith = 1'b1; end
      4'b0000: aluc = 2'b10;
      4'b1100: aluc = 2'b11;
      4'b1010: begin aluc = 2'b01; arith = 1'b1; is_cmp = 1'b1; end
      default: cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH:  state_n = memReady ? DECODE : FETCH;
      DECODE: begin
        if (cond_ok(cond, flags)) begin
          case (op)
            2'b01:   state_n = MEMADR;
            2'b00:   state_n = funct[5] ? EXECI : EXECR;
            2'b10:   state_n = BRANCH;
            default: state_n = FETCH;
          endcase
        end
`ifdef CTRL_HALT_EN
        if (cond == 4'b1111) state_n = HALT;
`endif
      end
      MEMADR: state_n = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_n = memReady ? MEMWB : MEMRD;
      MEMWR:  state_n = memReady ? FETCH : MEMWR;
      EXECR, EXECI: state_n = (is_cmp || !cmd_ok) ? FETCH : ALUWB;
`ifdef CTRL_HALT_EN
      HALT:   state_n = HALT;
`endif
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ctl   <= ctrl_of(FETCH, 2'b00, 1'b0);
      flags <= 4'b0000;
    end else begin
      state <= state_n;
      ctl   <= ctrl_of(state_n, cmd_ok ? aluc : 2'b00, rd == 4'hf);
      // Flags are written only on the edge that leaves an execute state.
      if (state == EXECR || state == EXECI) begin
        if (funct[0] || is_cmp)
          flags[3:2] <= ALUFlags[3:2];
        if (is_cmp || (funct[0] && arith))
          flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign fetch_go   = reset && (state == FETCH) && memReady;
  assign IRWrite    = fetch_go;
  assign PCWrite    = ctl.pcw | fetch_go;
  assign RegWrite   = ctl.regw;
  assign MemWrite   = ctl.memw;
  assign AdrSrc     = ctl.adr;
  assign ALUSrcA    = ctl.srca;
  assign ALUSrcB    = ctl.srcb;
  assign ResultSrc  = ctl.res;
  assign ALUControl = ctl.aluc;
  assign ImmSrc     = op;
  assign RegSrc     = {op == 2'b01, op == 2'b10};

endmodule
